// File: rtl/mult_seq_ctrl.sv
// Iterative shift-add unsigned multiplier controller: one multiplier bit per
// enabled step, product published only when an operation completes.
module mult_seq_ctrl #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               step_en,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   product_MSB,
  output logic [WIDTH-1:0]   product_LSB,
  output logic [5:0]         step_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [5:0] LAST_STEP = 6'(WIDTH);

  state_t             state;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;

  logic [2*WIDTH-1:0] acc_next;
  logic [5:0]         step_next;
  logic               run_exit;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    acc_next  = acc;
    step_next = step_count + 6'd1;
    run_exit  = 1'b0;
    if (mplier[0]) acc_next = acc + mcand;
    if (step_next == LAST_STEP) run_exit = 1'b1;
    if (EARLY_EXIT && ((mplier >> 1) == '0)) run_exit = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      product    <= '0;
      step_count <= '0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Cancel wins over start and over a coincident RUN exit; product untouched.
        state      <= IDLE;
        ready      <= 1'b1;
        busy       <= 1'b0;
        step_count <= '0;
      end else begin
        unique case (state)
          IDLE, DONE: begin
            if (start) begin
              mcand  <= {{WIDTH{1'b0}}, A};
              mplier <= B;
              state  <= LOAD;
              ready  <= 1'b0;
              busy   <= 1'b1;
            end else begin
              state <= IDLE;
              ready <= 1'b1;
              busy  <= 1'b0;
            end
          end
          LOAD: begin
            acc        <= '0;
            step_count <= '0;
            state      <= RUN;
          end
          RUN: begin
            if (step_en) begin
              acc        <= acc_next;
              mcand      <= mcand << 1;
              mplier     <= mplier >> 1;
              step_count <= step_next;
              if (run_exit) begin
                product <= acc_next;
                state   <= DONE;
                ready   <= 1'b1;
                busy    <= 1'b0;
                done    <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign product_MSB = product[2*WIDTH-1:WIDTH];
  assign product_LSB = product[WIDTH-1:0];

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: a full-width instance and an EARLY_EXIT
// instance share stimulus; vectors plus hand-written multi-cycle sequences.
module tb_mult_seq_ctrl;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          step_en = 1'b1;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;

  logic          ready0, busy0, done0, ready1, busy1, done1;
  logic [2*W-1:0] product0, product1;
  logic [W-1:0]  msb0, lsb0, msb1, lsb1;
  logic [5:0]    steps0, steps1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_seq_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .step_en(step_en),
    .A(A), .B(B), .ready(ready0), .busy(busy0), .done(done0),
    .product(product0), .product_MSB(msb0), .product_LSB(lsb0), .step_count(steps0)
  );

  mult_seq_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_early (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .step_en(step_en),
    .A(A), .B(B), .ready(ready1), .busy(busy1), .done(done1),
    .product(product1), .product_MSB(msb1), .product_LSB(lsb1), .step_count(steps1)
  );

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    bit             early;
    logic [2*W-1:0] exp_product;
    int             exp_steps;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!(ready0 && ready1) && n < budget) begin
      tick();
      n++;
    end
    check("ready_wait", {63'd0, ready0 && ready1}, 64'd1);
  endtask

  // Called at a negedge; pulses start for one edge and waits for done on the chosen instance.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit use_early,
                        output int edges, output int busy_cycles, output bit got_done);
    A = a;
    B = b;
    start = 1'b1;
    edges = 0;
    busy_cycles = 0;
    got_done = 1'b0;
    while (!got_done && edges < 400) begin
      tick();
      edges++;
      start = 1'b0;
      if (busy0) busy_cycles++;
      if (use_early ? done1 : done0) got_done = 1'b1;
    end
  endtask

  initial begin
    int  edges, busy_cycles, exp_steps, done_edge;
    bit  got_done, en_prev, saw_done;

    vecs[0] = '{a: 32'd3,          b: 32'd5,          early: 1'b0, exp_product: 64'h0000_0000_0000_000F, exp_steps: 32};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  early: 1'b0, exp_product: 64'hFFFF_FFFE_0000_0001, exp_steps: 32};
    vecs[2] = '{a: 32'h1234_5678,  b: 32'h0000_0010,  early: 1'b1, exp_product: 64'h0000_0001_2345_6780, exp_steps: 5};
    vecs[3] = '{a: 32'h1234_5678,  b: 32'h0000_0000,  early: 1'b1, exp_product: 64'h0,                   exp_steps: 1};

    // Reset state
    #12;
    check("rst_ready", {63'd0, ready0}, 64'd1);
    check("rst_busy", {63'd0, busy0}, 64'd0);
    check("rst_done", {63'd0, done0}, 64'd0);
    check("rst_product", product0, 64'd0);
    check("rst_steps", {58'd0, steps0}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      wait_ready(100);
      run_op(vecs[i].a, vecs[i].b, vecs[i].early, edges, busy_cycles, got_done);
      check($sformatf("v%0d_done_seen", i), {63'd0, got_done}, 64'd1);
      if (vecs[i].early) begin
        check($sformatf("v%0d_product", i), product1, vecs[i].exp_product);
        check($sformatf("v%0d_steps", i), {58'd0, steps1}, 64'(vecs[i].exp_steps));
        check($sformatf("v%0d_edges", i), 64'(edges), 64'(vecs[i].exp_steps + 2));
      end else begin
        check($sformatf("v%0d_product", i), product0, vecs[i].exp_product);
        check($sformatf("v%0d_msb", i), {32'd0, msb0}, {32'd0, vecs[i].exp_product[63:32]});
        check($sformatf("v%0d_lsb", i), {32'd0, lsb0}, {32'd0, vecs[i].exp_product[31:0]});
        check($sformatf("v%0d_steps", i), {58'd0, steps0}, 64'(vecs[i].exp_steps));
        check($sformatf("v%0d_latency", i), 64'(edges), 64'd34);
        check($sformatf("v%0d_busy_cycles", i), 64'(busy_cycles), 64'd33);
        tick();
        check($sformatf("v%0d_done_pulse", i), {63'd0, done0}, 64'd0);
        check($sformatf("v%0d_ready_after", i), {63'd0, ready0}, 64'd1);
        check($sformatf("v%0d_product_hold", i), product0, vecs[i].exp_product);
      end
    end

    // Paced stepping: step_en on every 4th edge, a stray start mid-RUN must be ignored.
    wait_ready(100);
    A = 32'd7;
    B = 32'd9;
    start = 1'b1;
    step_en = 1'b0;
    exp_steps = 0;
    done_edge = 0;
    for (int k = 1; k <= 400 && done_edge == 0; k++) begin
      en_prev = step_en;
      tick();
      if (k >= 3 && en_prev) exp_steps++;
      start = 1'b0;
      if (k == 19) begin
        A = 32'd1;
        B = 32'd1;
        start = 1'b1;
      end
      if (k == 40) check("paced_steps_mid", {58'd0, steps0}, 64'(exp_steps));
      if (done0) done_edge = k;
      step_en = ((k + 1) % 4 == 0);
    end
    step_en = 1'b1;
    check("paced_done_edge", 64'(done_edge), 64'd128);
    check("paced_product", product0, 64'd63);
    check("paced_steps", {58'd0, steps0}, 64'd32);

    // Abort after 10 steps: no done, product keeps 63, step_count cleared.
    wait_ready(100);
    A = 32'd100;
    B = 32'd200;
    start = 1'b1;
    saw_done = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      start = 1'b0;
      if (done0) saw_done = 1'b1;
    end
    check("abort_steps_before", {58'd0, steps0}, 64'd10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    if (done0) saw_done = 1'b1;
    check("abort_ready", {63'd0, ready0}, 64'd1);
    check("abort_busy", {63'd0, busy0}, 64'd0);
    check("abort_steps", {58'd0, steps0}, 64'd0);
    check("abort_product", product0, 64'd63);
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done0) saw_done = 1'b1;
    end
    check("abort_no_done", {63'd0, saw_done}, 64'd0);
    run_op(32'd100, 32'd200, 1'b0, edges, busy_cycles, got_done);
    check("post_abort_done", {63'd0, got_done}, 64'd1);
    check("post_abort_product", product0, 64'd20000);

    // Asynchronous reset mid-operation, checked before any clock edge.
    wait_ready(100);
    A = 32'd5;
    B = 32'd6;
    start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      start = 1'b0;
    end
    check("pre_rst_steps", {58'd0, steps0}, 64'd12);
    #1 rst = 1'b0;
    #1;
    check("midrst_product", product0, 64'd0);
    check("midrst_ready", {63'd0, ready0}, 64'd1);
    check("midrst_busy", {63'd0, busy0}, 64'd0);
    check("midrst_steps", {58'd0, steps0}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    run_op(32'd5, 32'd6, 1'b0, edges, busy_cycles, got_done);
    check("post_rst_done", {63'd0, got_done}, 64'd1);
    check("post_rst_product", product0, 64'd30);
    check("post_rst_latency", 64'(edges), 64'd34);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
